// File: rtl/uart_mmio_pkg.sv
// Shared definitions for the memory-mapped UART: register offsets, STATUS bit positions,
// access-size code, serializer/deserializer state encoding and the bit-period clamp.
package uart_mmio_pkg;

  localparam logic [3:0] UART_DATA   = 4'h0;
  localparam logic [3:0] UART_STATUS = 4'h4;
  localparam logic [3:0] UART_DIV    = 4'h8;

  localparam int ST_TX_FULL  = 0;
  localparam int ST_TX_EMPTY = 1;
  localparam int ST_RX_VALID = 2;
  localparam int ST_RX_OVR   = 3;
  localparam int ST_TX_BUSY  = 4;

  localparam logic [2:0] SIZE_WORD = 3'b010;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

  // A divisor below 2 would leave no room for the RX half-bit wait.
  function automatic logic [15:0] eff_div(input logic [15:0] d);
    return (d < 16'd2) ? 16'd2 : d;
  endfunction

endpackage

// File: rtl/uart_mmio_sync_fifo.sv
// Generic synchronous FIFO, depth 2**AW; dout is the head entry, combinational, no read latency.
// Pushes while full and pops while empty are ignored without any state change.
module sync_fifo #(
  parameter int W  = 8,
  parameter int AW = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  logic [W-1:0]  mem [2**AW];
  logic [AW-1:0] wp, rp;
  logic [AW:0]   cnt;
  logic          do_push, do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign full    = cnt[AW];
  assign empty   = (cnt == '0);
  assign dout    = mem[rp];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (do_push) wp <= wp + AW'(1);
      if (do_pop)  rp <= rp + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= din;
  end

endmodule

// File: rtl/uart_mmio.sv
// Memory-mapped 8N1 UART: stores queue bytes in a TX FIFO drained by the serializer, the receiver
// fills one holding register. Loads return registered data one cycle after the access.
module uart_mmio
  import uart_mmio_pkg::*;
#(
  parameter int          FIFO_AW   = 3,
  parameter logic [15:0] DIV_RESET = 16'd104
) (
  input  logic        CLK,
  input  logic        rst,
  input  logic        sel,
  input  logic        en,
  input  logic        wr_rd,
  input  logic [2:0]  size,
  input  logic [3:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        tx,
  input  logic        rx,
  output logic        irq
);

  logic        acc, st, ld, ld_data, ld_status;
  logic [15:0] div, bit_len, half_len;
  logic        fifo_full, fifo_empty, fifo_push;
  logic [7:0]  fifo_dout;
  logic        rx_valid, rx_ovr, ferr;
  logic [7:0]  rx_byte;
  logic [31:0] status;
  logic        unused_wdata;

  assign acc       = sel & en;
  assign st        = acc & wr_rd;
  assign ld        = acc & ~wr_rd;
  assign ld_data   = ld & (addr == UART_DATA);
  assign ld_status = ld & (addr == UART_STATUS);
  assign fifo_push = st & (addr == UART_DATA);
  assign bit_len   = eff_div(div) - 16'd1;
  assign half_len  = (eff_div(div) >> 1) - 16'd1;
  assign unused_wdata = ^wdata[31:16];

  // ---------------- TX serializer ----------------
  uart_state_t tx_state, tx_state_n;
  logic [15:0] tx_cnt, tx_cnt_n;
  logic [2:0]  tx_bit, tx_bit_n;
  logic [7:0]  tx_shr, tx_shr_n;
  logic        tx_pop, tx_busy;

  sync_fifo #(.W(8), .AW(FIFO_AW)) u_fifo (
    .clk(CLK), .rst(rst), .push(fifo_push), .pop(tx_pop), .din(wdata[7:0]),
    .dout(fifo_dout), .full(fifo_full), .empty(fifo_empty)
  );

  // Bit counters reload from the live divisor at each boundary, so DIV writes land on the next bit.
  always_comb begin
    tx_state_n = tx_state;
    tx_cnt_n   = tx_cnt;
    tx_bit_n   = tx_bit;
    tx_shr_n   = tx_shr;
    tx_pop     = 1'b0;
    case (tx_state)
      IDLE: if (!fifo_empty) begin
        tx_pop = 1'b1; tx_shr_n = fifo_dout; tx_cnt_n = bit_len; tx_state_n = START;
      end
      START: if (tx_cnt == '0) begin
        tx_state_n = DATA; tx_bit_n = '0; tx_cnt_n = bit_len;
      end else tx_cnt_n = tx_cnt - 16'd1;
      DATA: if (tx_cnt == '0) begin
        tx_shr_n = {1'b0, tx_shr[7:1]}; tx_bit_n = tx_bit + 3'd1; tx_cnt_n = bit_len;
        if (tx_bit == 3'd7) tx_state_n = STOP;
      end else tx_cnt_n = tx_cnt - 16'd1;
      STOP: if (tx_cnt == '0) begin
        if (!fifo_empty) begin
          tx_pop = 1'b1; tx_shr_n = fifo_dout; tx_cnt_n = bit_len; tx_state_n = START;
        end else tx_state_n = IDLE;
      end else tx_cnt_n = tx_cnt - 16'd1;
      default: tx_state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      tx_state <= IDLE; tx_cnt <= '0; tx_bit <= '0; tx_shr <= '0;
    end else begin
      tx_state <= tx_state_n; tx_cnt <= tx_cnt_n; tx_bit <= tx_bit_n; tx_shr <= tx_shr_n;
    end
  end

  assign tx_busy = (tx_state != IDLE);
  assign tx      = (tx_state == START) ? 1'b0 : (tx_state == DATA) ? tx_shr[0] : 1'b1;

  // ---------------- RX deserializer ----------------
  uart_state_t rx_state, rx_state_n;
  logic [15:0] rx_cnt, rx_cnt_n;
  logic [2:0]  rx_bit, rx_bit_n;
  logic [7:0]  rx_shr, rx_shr_n;
  logic        rx_s1, rx_s2, rx_d, rx_done, rx_ok, rx_bad;

  always_comb begin
    rx_state_n = rx_state;
    rx_cnt_n   = rx_cnt;
    rx_bit_n   = rx_bit;
    rx_shr_n   = rx_shr;
    rx_done    = 1'b0;
    case (rx_state)
      IDLE: if (rx_d & ~rx_s2) begin
        rx_state_n = START; rx_cnt_n = half_len;
      end
      START: if (rx_cnt == '0) begin
        rx_state_n = rx_s2 ? IDLE : DATA; rx_bit_n = '0; rx_cnt_n = bit_len;
      end else rx_cnt_n = rx_cnt - 16'd1;
      DATA: if (rx_cnt == '0) begin
        rx_shr_n = {rx_s2, rx_shr[7:1]}; rx_bit_n = rx_bit + 3'd1; rx_cnt_n = bit_len;
        if (rx_bit == 3'd7) rx_state_n = STOP;
      end else rx_cnt_n = rx_cnt - 16'd1;
      STOP: if (rx_cnt == '0) begin
        rx_done = 1'b1; rx_state_n = IDLE;
      end else rx_cnt_n = rx_cnt - 16'd1;
      default: rx_state_n = IDLE;
    endcase
  end

  assign rx_ok  = rx_done & rx_s2;
  assign rx_bad = rx_done & ~rx_s2;

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      rx_state <= IDLE; rx_cnt <= '0; rx_bit <= '0; rx_shr <= '0;
      rx_s1 <= 1'b1; rx_s2 <= 1'b1; rx_d <= 1'b1;
    end else begin
      rx_state <= rx_state_n; rx_cnt <= rx_cnt_n; rx_bit <= rx_bit_n; rx_shr <= rx_shr_n;
      rx_s1 <= rx; rx_s2 <= rx_s1; rx_d <= rx_s2;
    end
  end

  // ---------------- Registers and load path ----------------
  always_comb begin
    status              = '0;
    status[ST_TX_FULL]  = fifo_full;
    status[ST_TX_EMPTY] = fifo_empty;
    status[ST_RX_VALID] = rx_valid;
    status[ST_RX_OVR]   = rx_ovr;
    status[ST_TX_BUSY]  = tx_busy;
  end

  // A byte landing on the same edge as a DATA load survives: the load took the old byte.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      div <= DIV_RESET; rx_valid <= 1'b0; rx_ovr <= 1'b0; ferr <= 1'b0;
      rx_byte <= '0; rdata <= '0;
    end else begin
      if (st && addr == UART_DIV && size == SIZE_WORD) div <= wdata[15:0];
      if (rx_ok) rx_byte <= rx_shr;
      if (rx_ok) rx_valid <= 1'b1;
      else if (ld_data) rx_valid <= 1'b0;
      if (rx_ok && rx_valid && !ld_data) rx_ovr <= 1'b1;
      else if (ld_status) rx_ovr <= 1'b0;
      ferr <= rx_bad | (ferr & ~ld_status);
      if (ld) begin
        case (addr)
          UART_DATA:   rdata <= rx_valid ? {24'b0, rx_byte} : 32'b0;
          UART_STATUS: rdata <= status;
          UART_DIV:    rdata <= {16'b0, div};
          default:     rdata <= 32'b0;
        endcase
      end
    end
  end

  assign irq = rx_valid | (fifo_empty & ~tx_busy);

endmodule

// File: tb/tb_uart_mmio.sv
// Self-checking bench for uart_mmio: bus tasks, a line-level TX decoder and a byte-level RX/TX model.
module tb_uart_mmio;

  logic        CLK = 1'b0, rst = 1'b1, sel = 1'b0, en = 1'b0, wr_rd = 1'b0, rx = 1'b1;
  logic [2:0]  size = '0;
  logic [3:0]  addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        tx, irq;

  uart_mmio #(.FIFO_AW(3), .DIV_RESET(16'd104)) dut (
    .CLK(CLK), .rst(rst), .sel(sel), .en(en), .wr_rd(wr_rd), .size(size),
    .addr(addr), .wdata(wdata), .rdata(rdata), .tx(tx), .rx(rx), .irq(irq)
  );

  always #5 CLK = ~CLK;

  int checks = 0, errors = 0;

  // Model: bytes the line should carry, bytes decoded from the line, receive-side flags.
  logic [7:0]  exp_tx[$];
  logic [7:0]  mon_q[$];
  int          mon_starts = 0, mon_bad = 0, m_acc = 0, mon_div = 104;
  logic [15:0] m_div = 16'd104;
  logic        m_valid = 1'b0, m_ovr = 1'b0;
  logic [7:0]  m_byte = '0;

  initial begin : tx_mon
    logic [9:0] f;
    logic       ab;
    forever begin
      @(posedge CLK); #1;
      if (!rst && tx === 1'b0) begin
        mon_starts++;
        ab = 1'b0;
        f  = '0;
        for (int i = 0; i < 10; i++) begin
          repeat ((i == 0) ? mon_div / 2 : mon_div) begin
            @(posedge CLK); #1;
            if (rst) ab = 1'b1;
          end
          f[i] = tx;
        end
        if (!ab) begin
          mon_q.push_back(f[8:1]);
          if (f[0] !== 1'b0 || f[9] !== 1'b1) mon_bad++;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required summary");
    $fatal(1, "timeout");
  end

  // Bus tasks are entered on a falling edge and return on the falling edge after the access.
  task automatic store(input logic [3:0] a, input logic [31:0] d, input logic [2:0] s);
    sel = 1'b1; en = 1'b1; wr_rd = 1'b1; addr = a; wdata = d; size = s;
    if (a == 4'h0 && (m_acc - mon_starts) < 8) begin
      exp_tx.push_back(d[7:0]);
      m_acc++;
    end
    if (a == 4'h8 && s == 3'b010) begin
      m_div   = d[15:0];
      mon_div = (m_div < 16'd2) ? 2 : int'(m_div);
    end
    @(negedge CLK);
    sel = 1'b0; en = 1'b0; wr_rd = 1'b0;
  endtask

  task automatic load(input logic [3:0] a, output logic [31:0] v);
    sel = 1'b1; en = 1'b1; wr_rd = 1'b0; addr = a; size = 3'b010;
    @(negedge CLK);
    sel = 1'b0; en = 1'b0;
    v = rdata;
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop, input int d);
    rx = 1'b0;
    repeat (d) @(negedge CLK);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (d) @(negedge CLK);
    end
    rx = stop;
    repeat (d) @(negedge CLK);
    rx = 1'b1;
    repeat (d) @(negedge CLK);
    if (stop) begin
      if (m_valid) m_ovr = 1'b1;
      m_byte  = b;
      m_valid = 1'b1;
    end
  endtask

  task automatic test_reset();
    logic [31:0] v;
    repeat (3) @(negedge CLK);
    checks++; if (tx !== 1'b1)     begin errors++; $display("FAIL reset_tx: got %b required 1", tx); end
    checks++; if (irq !== 1'b1)    begin errors++; $display("FAIL reset_irq: got %b required 1", irq); end
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h required 0", rdata); end
    rst = 1'b0;
    @(negedge CLK);
    load(4'h4, v);
    checks++; if (v !== 32'h2)  begin errors++; $display("FAIL reset_status: got %h required 2", v); end
    load(4'h8, v);
    checks++; if (v !== 32'd104) begin errors++; $display("FAIL reset_div: got %0d required 104", v); end
    load(4'h0, v);
    checks++; if (v !== 32'h0)  begin errors++; $display("FAIL reset_data: got %h required 0", v); end
  endtask

  task automatic test_tx_frame();
    logic [31:0] v;
    logic [7:0]  b;
    logic        e;
    int          w;
    @(negedge CLK);
    store(4'h8, 32'd4, 3'b010);
    load(4'h8, v);
    checks++; if (v !== 32'd4) begin errors++; $display("FAIL div_write: got %0d required 4", v); end
    b = 8'h55;
    mon_q.delete(); exp_tx.delete();
    store(4'h0, {$urandom_range(0, 32'hFFFFFF), b}, 3'($urandom_range(0, 2)));
    w = 0;
    @(posedge CLK); #1;
    while (tx !== 1'b0 && w < 6) begin @(posedge CLK); #1; w++; end
    checks++; if (tx !== 1'b0) begin errors++; $display("FAIL tx_start: got %b required 0 within 6 cycles", tx); end
    for (int i = 0; i < 40; i++) begin
      e = (i < 4) ? 1'b0 : (i < 36) ? b[(i - 4) / 4] : 1'b1;
      checks++; if (tx !== e) begin errors++; $display("FAIL tx_wave[%0d]: got %b required %b", i, tx, e); end
      if (i == 20) begin
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_busy: got %b required 0", irq); end
      end
      @(posedge CLK); #1;
    end
    w = 0;
    while (irq !== 1'b1 && w < 3) begin @(posedge CLK); #1; w++; end
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_after_stop: got %b required 1", irq); end
    checks++; if (mon_q.size() != 1 || mon_q[0] !== exp_tx[0])
      begin errors++; $display("FAIL tx_decode: got %0d bytes required 1 byte %h", mon_q.size(), exp_tx[0]); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] v, e;
    int          occ, w;
    @(negedge CLK);
    mon_q.delete(); exp_tx.delete();
    for (int i = 0; i < 9; i++) store(4'h0, $urandom, 3'($urandom_range(0, 2)));
    occ = m_acc - mon_starts;
    e = {27'b0, 1'b1, m_ovr, m_valid, occ == 0, occ == 8};
    load(4'h4, v);
    checks++; if (v !== e) begin errors++; $display("FAIL status_full: got %h required %h", v, e); end
    store(4'h0, $urandom, 3'b010);
    w = 0;
    while (mon_q.size() < exp_tx.size() && w < 3000) begin @(negedge CLK); w++; end
    repeat (100) @(negedge CLK);
    checks++; if (mon_q.size() != exp_tx.size())
      begin errors++; $display("FAIL b2b_count: got %0d frames required %0d", mon_q.size(), exp_tx.size()); end
    for (int i = 0; i < exp_tx.size() && i < mon_q.size(); i++) begin
      checks++; if (mon_q[i] !== exp_tx[i])
        begin errors++; $display("FAIL b2b_byte[%0d]: got %h required %h", i, mon_q[i], exp_tx[i]); end
    end
    checks++; if (mon_bad != 0) begin errors++; $display("FAIL b2b_framing: got %0d bad frames required 0", mon_bad); end
    load(4'h4, v);
    checks++; if (v !== 32'h2) begin errors++; $display("FAIL b2b_idle_status: got %h required 2", v); end
  endtask

  task automatic test_regs();
    logic [31:0] v;
    int          s0, w;
    @(negedge CLK);
    store(4'h8, 32'h0000_1234, 3'b000);
    store(4'h8, 32'h0000_4321, 3'b001);
    load(4'h8, v);
    checks++; if (v !== {16'b0, m_div}) begin errors++; $display("FAIL div_subword: got %h required %h", v, m_div); end
    s0 = mon_starts;
    store(4'hC, $urandom, 3'b010);
    store(4'h1, $urandom, 3'b000);
    store(4'h4, $urandom, 3'b010);
    repeat (4) @(negedge CLK);
    load(4'h4, v);
    checks++; if (v !== 32'h2) begin errors++; $display("FAIL ignored_stores: got %h required 2", v); end
    checks++; if (mon_starts != s0) begin errors++; $display("FAIL ignored_tx: got %0d starts required %0d", mon_starts, s0); end
    load(4'hC, v);
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL load_0xc: got %h required 0", v); end
    load(4'h9, v);
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL load_0x9: got %h required 0", v); end
    store(4'h8, 32'hFFFF_0001, 3'b010);
    load(4'h8, v);
    checks++; if (v !== 32'h1) begin errors++; $display("FAIL div_raw: got %h required 1", v); end
    mon_q.delete(); exp_tx.delete();
    store(4'h0, $urandom, 3'b000);
    store(4'h0, $urandom, 3'b000);
    w = 0;
    while (mon_q.size() < 2 && w < 500) begin @(negedge CLK); w++; end
    repeat (30) @(negedge CLK);
    checks++; if (mon_q.size() != 2) begin errors++; $display("FAIL div_min_count: got %0d required 2", mon_q.size()); end
    for (int i = 0; i < 2 && i < mon_q.size(); i++) begin
      checks++; if (mon_q[i] !== exp_tx[i])
        begin errors++; $display("FAIL div_min_byte[%0d]: got %h required %h", i, mon_q[i], exp_tx[i]); end
    end
  endtask

  task automatic test_rx();
    logic [31:0] v, e;
    @(negedge CLK);
    store(4'h8, 32'd8, 3'b010);
    send_rx(8'hA3, 1'b1, 8);
    e = {27'b0, 1'b0, m_ovr, m_valid, 1'b1, 1'b0};
    load(4'h4, v); m_ovr = 1'b0;
    checks++; if (v !== e) begin errors++; $display("FAIL rx_status: got %h required %h", v, e); end
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL rx_irq: got %b required 1", irq); end
    e = m_valid ? {24'b0, m_byte} : 32'b0; m_valid = 1'b0;
    load(4'h0, v);
    checks++; if (v !== e) begin errors++; $display("FAIL rx_data: got %h required %h", v, e); end
    e = {27'b0, 1'b0, m_ovr, m_valid, 1'b1, 1'b0};
    load(4'h4, v);
    checks++; if (v !== e) begin errors++; $display("FAIL rx_status_clr: got %h required %h", v, e); end
    repeat (3) @(negedge CLK);
    checks++; if (rdata !== e) begin errors++; $display("FAIL rdata_hold: got %h required %h", rdata, e); end
    send_rx(8'($urandom), 1'b1, 8);
    e = m_valid ? {24'b0, m_byte} : 32'b0; m_valid = 1'b0;
    load(4'h0, v);
    checks++; if (v !== e) begin errors++; $display("FAIL rx_data_rand: got %h required %h", v, e); end
  endtask

  task automatic test_overrun();
    logic [31:0] v, e;
    @(negedge CLK);
    send_rx(8'($urandom), 1'b1, 8);
    send_rx(8'($urandom), 1'b1, 8);
    e = {27'b0, 1'b0, m_ovr, m_valid, 1'b1, 1'b0};
    load(4'h4, v); m_ovr = 1'b0;
    checks++; if (v !== e) begin errors++; $display("FAIL ovr_status: got %h required %h", v, e); end
    e = m_valid ? {24'b0, m_byte} : 32'b0; m_valid = 1'b0;
    load(4'h0, v);
    checks++; if (v !== e) begin errors++; $display("FAIL ovr_data: got %h required %h", v, e); end
    e = {27'b0, 1'b0, m_ovr, m_valid, 1'b1, 1'b0};
    load(4'h4, v);
    checks++; if (v !== e) begin errors++; $display("FAIL ovr_clear: got %h required %h", v, e); end
  endtask

  task automatic test_false_start();
    logic [31:0] v, e;
    @(negedge CLK);
    rx = 1'b0;
    repeat (2) @(negedge CLK);
    rx = 1'b1;
    repeat (40) @(negedge CLK);
    load(4'h4, v);
    checks++; if (v !== 32'h2) begin errors++; $display("FAIL false_start: got %h required 2", v); end
    send_rx(8'($urandom), 1'b0, 8);
    load(4'h4, v);
    checks++; if (v !== 32'h2) begin errors++; $display("FAIL ferr_frame: got %h required 2", v); end
    send_rx(8'($urandom), 1'b1, 8);
    e = m_valid ? {24'b0, m_byte} : 32'b0; m_valid = 1'b0;
    load(4'h0, v);
    checks++; if (v !== e) begin errors++; $display("FAIL rx_recover: got %h required %h", v, e); end
  endtask

  task automatic test_reset_midframe();
    logic [31:0] v;
    int          s0;
    @(negedge CLK);
    store(4'h8, 32'd4, 3'b010);
    for (int i = 0; i < 4; i++) store(4'h0, $urandom, 3'b000);
    repeat (12) @(negedge CLK);
    rst = 1'b1;
    #1;
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL rst_tx: got %b required 1", tx); end
    repeat (2) @(negedge CLK);
    rst = 1'b0;
    exp_tx.delete(); mon_q.delete();
    m_acc = mon_starts; m_div = 16'd104; mon_div = 104; m_valid = 1'b0; m_ovr = 1'b0;
    s0 = mon_starts;
    load(4'h4, v);
    checks++; if (v !== 32'h2) begin errors++; $display("FAIL rst_status: got %h required 2", v); end
    load(4'h8, v);
    checks++; if (v !== {16'b0, m_div}) begin errors++; $display("FAIL rst_div: got %0d required %0d", v, m_div); end
    repeat (300) @(negedge CLK);
    checks++; if (mon_starts != s0 || tx !== 1'b1)
      begin errors++; $display("FAIL rst_no_frames: got %0d starts tx=%b required %0d tx=1", mon_starts, tx, s0); end
  endtask

  initial begin
    test_reset();
    test_tx_frame();
    test_back_to_back();
    test_regs();
    test_rx();
    test_overrun();
    test_false_start();
    test_reset_midframe();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
